snoop_responder: RTL and testbench
==================================

Name: snoop_responder

Overview:
- Services snooped bus operations from other caches on behalf of our L2.
- Per snoop: one lookup of the external tag/MESI array, then the snoop result (HIT/HITM/NOHIT), then any L1 back-invalidate/get message, dirty-line writeback and MESI state update.
- Sits between the bus snoop interface, the L2 tag/state array and the L2→L1 message channel.
- It is the responding end to the L2 initiator's bus operations.

Parameters:
WAYS, 8, associativity (power of two)
IDX_W, 15, set index bits
OFF_W, 6, byte-offset bits (64 B line)
TAG_W, 32-IDX_W-OFF_W (11), tag bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
snp_valid  in  1  snoop request valid
snp_ready  out  1  high only in IDLE
snp_cmd  in  4  command encoding (SNOOP_INVAL=3, SNOOPED_RD=4, SNOOP_WR=5, SNOOP_RDWITM=6)
snp_addr  in  32  snooped address
arr_rd_en  out  1  array read strobe; data returns next cycle
arr_rd_index  out  IDX_W  set index
arr_rd_tag  in  WAYS*TAG_W  tags of all ways; way w at [w*TAG_W +: TAG_W]
arr_rd_state  in  WAYS*2  MESI of all ways (M=3, S=2, E=1, I=0)
arr_wr_en  out  1  state write strobe
arr_wr_index  out  IDX_W  set
arr_wr_way  out  log2(WAYS)  way
arr_wr_state  out  2  new MESI state
snp_result_valid  out  1  one-cycle pulse
snp_result  out  2  HIT=0, HITM=1, NOHIT=2
l1_msg_valid  out  1  L1 message valid
l1_msg  out  3  GETLINE=1, SENDLINE=2, INVALLINE=3, EVICTLINE=4
l1_msg_addr  out  32  line address, offset bits zero
l1_msg_ready  in  1  L1 accepts
wb_valid  out  1  bus writeback (BWRITE) request
wb_addr  out  32  line address, offset bits zero
wb_ready  in  1  bus accepts writeback
err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset: FSM to IDLE. snp_ready=1. All other outputs 0, except snp_result=NOHIT (2). Reset mid-transaction aborts it: no array write, no pending message.
- Address split: offset = addr[OFF_W-1:0]; index = addr[OFF_W+IDX_W-1:OFF_W]; tag = remaining upper bits. Command and address are registered at acceptance (snp_valid & snp_ready).
- Timing, with acceptance in cycle T:
  - T+1 LOOKUP: arr_rd_en=1.
  - T+2 COMPARE: hit = state≠I and tag equal. Multiple hitting ways: use lowest way, pulse err.
  - T+3 RESULT: snp_result_valid=1. Fixed latency of 3 cycles from acceptance.
- States: IDLE → LOOKUP → COMPARE → RESULT → [L1MSG] → [WB] → [UPDATE] → IDLE. Bracketed states are skipped when the action table below requires nothing.
- L1MSG and WB hold valid and address stable until ready. Transfer completes in the cycle valid & ready.
- UPDATE asserts arr_wr_en for one cycle.
- Action table (result / L1 message / writeback / next state):
  - SNOOPED_RD, M: HITM / GETLINE / yes / S
  - SNOOPED_RD, E: HIT / none / no / S
  - SNOOPED_RD, S: HIT / none / no / no write
  - SNOOP_RDWITM, M: HITM / EVICTLINE / yes / I
  - SNOOP_RDWITM, E or S: HIT / INVALLINE / no / I
  - SNOOP_INVAL, S: HIT / INVALLINE / no / I
  - SNOOP_INVAL, M or E: NOHIT, no action, err pulse
  - SNOOP_WR, any state: NOHIT, no action
  - Miss, any command: NOHIT, no action
  - Any other snp_cmd value: accepted, NOHIT, no side effects, no err
- Ordering for HITM: the L1 message completes before the writeback, so the writeback carries the freshest data.
- No new snoop is accepted until the FSM returns to IDLE. There is no pipelining.
- Simultaneous ready and valid: completes in that cycle. Back-to-back transactions are allowed from the next IDLE cycle.

Decomposition:
- Shared package holds:
  - snoop result constants HIT/HITM/NOHIT
  - MESI state enum
  - command enum
  - L2_L1 message enum
  - bus operation enum
  - WAYS
  - FSM state typedef
- Sub-module way_match:
  - Combinational tag compare plus priority encoder.
  - Outputs: hit, way index, way state, multi-hit.

Test Plan:
- Array way 3 at index 0x0010 holds tag 0x055 in M. SNOOPED_RD to address {0x055, 0x0010, 6'h00}, with l1_msg_ready/wb_ready tied 1. Expect: snp_result=HITM at T+3, l1_msg=GETLINE, then wb_valid, then arr_wr way3 state S. Back in IDLE by T+7.
- Same set, way 5 in E. SNOOP_RDWITM expects HIT, INVALLINE, no wb_valid, arr_wr state I.
- SNOOPED_RD to a tag absent from the set expects NOHIT, no l1_msg_valid, no wb_valid, no arr_wr_en, snp_ready back at T+4.
- HITM case with l1_msg_ready held low for 5 cycles expects l1_msg_valid, l1_msg and l1_msg_addr stable throughout, wb_valid not asserted before the L1 handshake.
- Two ways matching the same tag with state ≠ I expects lowest way used, err pulse in COMPARE.
- rst asserted while in WB state expects IDLE next cycle, wb_valid=0, no arr_wr_en, snp_ready=1.

Source files
------------

// File: rtl/snoop_responder_pkg.sv
// Shared types and constants for the snoop responder: array geometry, MESI,
// bus-snoop commands, L2->L1 messages and the responder's FSM encoding.
package snoop_responder_pkg;

    localparam int WAYS  = 8;
    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = 15;
    localparam int OFF_W = 6;
    localparam int TAG_W = 32 - IDX_W - OFF_W;

    localparam logic [1:0] SNP_HIT   = 2'd0;
    localparam logic [1:0] SNP_HITM  = 2'd1;
    localparam logic [1:0] SNP_NOHIT = 2'd2;

    typedef enum logic [1:0] {
        MESI_I = 2'd0, MESI_E = 2'd1, MESI_S = 2'd2, MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [3:0] {
        CMD_SNOOP_INVAL  = 4'd3,
        CMD_SNOOPED_RD   = 4'd4,
        CMD_SNOOP_WR     = 4'd5,
        CMD_SNOOP_RDWITM = 4'd6
    } cmd_e;

    typedef enum logic [2:0] {
        L1_NONE = 3'd0, L1_GETLINE = 3'd1, L1_SENDLINE = 3'd2,
        L1_INVALLINE = 3'd3, L1_EVICTLINE = 3'd4
    } l1_msg_e;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0, BUS_BREAD = 2'd1, BUS_BWRITE = 2'd2, BUS_BRDWITM = 2'd3
    } bus_op_e;

    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE    = 3'd0;
    localparam fsm_state_t ST_LOOKUP  = 3'd1;
    localparam fsm_state_t ST_COMPARE = 3'd2;
    localparam fsm_state_t ST_RESULT  = 3'd3;
    localparam fsm_state_t ST_L1MSG   = 3'd4;
    localparam fsm_state_t ST_WB      = 3'd5;
    localparam fsm_state_t ST_UPDATE  = 3'd6;

    typedef struct packed {
        logic [1:0] result;
        l1_msg_e    msg;
        logic       wb;
        logic       wr;
        mesi_e      new_state;
        logic       err;
    } action_t;

    // Everything a snoop does once the lookup outcome is known.
    function automatic action_t decode_action(logic [3:0] cmd, logic hit, mesi_e mesi);
        action_t a;
        a.result    = SNP_NOHIT;
        a.msg       = L1_NONE;
        a.wb        = 1'b0;
        a.wr        = 1'b0;
        a.new_state = MESI_I;
        a.err       = 1'b0;
        if (hit) begin
            case (cmd)
                CMD_SNOOPED_RD: begin
                    a.result = (mesi == MESI_M) ? SNP_HITM : SNP_HIT;
                    if (mesi == MESI_M) begin
                        a.msg = L1_GETLINE;
                        a.wb  = 1'b1;
                    end
                    a.wr        = (mesi != MESI_S);
                    a.new_state = MESI_S;
                end
                CMD_SNOOP_RDWITM: begin
                    a.result = (mesi == MESI_M) ? SNP_HITM : SNP_HIT;
                    a.msg    = (mesi == MESI_M) ? L1_EVICTLINE : L1_INVALLINE;
                    a.wb     = (mesi == MESI_M);
                    a.wr     = 1'b1;
                end
                CMD_SNOOP_INVAL: begin
                    if (mesi == MESI_S) begin
                        a.result = SNP_HIT;
                        a.msg    = L1_INVALLINE;
                        a.wr     = 1'b1;
                    end else begin
                        a.err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        return a;
    endfunction

endpackage

// File: rtl/snoop_responder_way_match.sv
// Tag compare across all ways with a lowest-way-wins priority encoder.
module snoop_responder_way_match
    import snoop_responder_pkg::*;
(
    input  logic [TAG_W-1:0]      tag,
    input  logic [WAYS*TAG_W-1:0] way_tags,
    input  logic [WAYS*2-1:0]     way_states,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [1:0]            hit_state,
    output logic                  multi_hit
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit       = 1'b0;
        hit_way   = '0;
        hit_state = MESI_I;
        multi_hit = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_states[w*2 +: 2] != MESI_I && way_tags[w*TAG_W +: TAG_W] == tag) begin
                if (hit) begin
                    multi_hit = 1'b1;
                end else begin
                    hit       = 1'b1;
                    hit_way   = WAY_W'(w);
                    hit_state = way_states[w*2 +: 2];
                end
            end
        end
    end

endmodule

// File: rtl/snoop_responder.sv
// Responds to bus snoops for the L2: tag lookup, snoop result, then optional
// L1 message, dirty writeback and MESI update, one snoop at a time.
module snoop_responder
    import snoop_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snp_valid,
    output logic                  snp_ready,
    input  logic [3:0]            snp_cmd,
    input  logic [31:0]           snp_addr,
    output logic                  arr_rd_en,
    output logic [IDX_W-1:0]      arr_rd_index,
    input  logic [WAYS*TAG_W-1:0] arr_rd_tag,
    input  logic [WAYS*2-1:0]     arr_rd_state,
    output logic                  arr_wr_en,
    output logic [IDX_W-1:0]      arr_wr_index,
    output logic [WAY_W-1:0]      arr_wr_way,
    output logic [1:0]            arr_wr_state,
    output logic                  snp_result_valid,
    output logic [1:0]            snp_result,
    output logic                  l1_msg_valid,
    output logic [2:0]            l1_msg,
    output logic [31:0]           l1_msg_addr,
    input  logic                  l1_msg_ready,
    output logic                  wb_valid,
    output logic [31:0]           wb_addr,
    input  logic                  wb_ready,
    output logic                  err
);

    localparam int LINE_W = 32 - OFF_W;

    fsm_state_t        state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [1:0]        result_q, result_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [2:0]        msg_q, msg_d;
    logic              wb_q, wb_d;
    logic              wr_q, wr_d;
    logic [1:0]        new_state_q, new_state_d;

    logic              hit, multi_hit;
    logic [WAY_W-1:0]  hit_way;
    logic [1:0]        hit_state;
    action_t           act;
    logic              unused_offset;

    assign unused_offset = ^snp_addr[OFF_W-1:0];

    snoop_responder_way_match u_way_match (
        .tag        (line_q[IDX_W +: TAG_W]),
        .way_tags   (arr_rd_tag),
        .way_states (arr_rd_state),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_state  (hit_state),
        .multi_hit  (multi_hit)
    );

    assign act = decode_action(cmd_q, hit, mesi_e'(hit_state));

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        line_d      = line_q;
        result_d    = result_q;
        way_d       = way_q;
        msg_d       = msg_q;
        wb_d        = wb_q;
        wr_d        = wr_q;
        new_state_d = new_state_q;
        case (state_q)
            ST_IDLE: begin
                if (snp_valid) begin
                    cmd_d   = snp_cmd;
                    line_d  = snp_addr[31:OFF_W];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP:  state_d = ST_COMPARE;
            ST_COMPARE: begin
                result_d    = act.result;
                msg_d       = act.msg;
                wb_d        = act.wb;
                wr_d        = act.wr;
                new_state_d = act.new_state;
                way_d       = hit_way;
                state_d     = ST_RESULT;
            end
            // Skip the stages this snoop has no work for; L1 goes before WB so
            // the writeback carries whatever the L1 handed back.
            ST_RESULT: begin
                if (msg_q != L1_NONE) state_d = ST_L1MSG;
                else if (wb_q)        state_d = ST_WB;
                else if (wr_q)        state_d = ST_UPDATE;
                else                  state_d = ST_IDLE;
            end
            ST_L1MSG: begin
                if (l1_msg_ready) state_d = wb_q ? ST_WB : (wr_q ? ST_UPDATE : ST_IDLE);
            end
            ST_WB: begin
                if (wb_ready) state_d = wr_q ? ST_UPDATE : ST_IDLE;
            end
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; every flop
        // is reset so an aborted snoop leaves nothing stale on the outputs.
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            line_q      <= '0;
            result_q    <= SNP_NOHIT;
            way_q       <= '0;
            msg_q       <= L1_NONE;
            wb_q        <= 1'b0;
            wr_q        <= 1'b0;
            new_state_q <= MESI_I;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            line_q      <= line_d;
            result_q    <= result_d;
            way_q       <= way_d;
            msg_q       <= msg_d;
            wb_q        <= wb_d;
            wr_q        <= wr_d;
            new_state_q <= new_state_d;
        end
    end

    assign snp_ready        = (state_q == ST_IDLE);
    assign arr_rd_en        = (state_q == ST_LOOKUP);
    assign arr_rd_index     = line_q[IDX_W-1:0];
    assign err              = (state_q == ST_COMPARE) && (multi_hit || act.err);
    assign snp_result_valid = (state_q == ST_RESULT);
    assign snp_result       = result_q;
    assign l1_msg_valid     = (state_q == ST_L1MSG);
    assign l1_msg           = msg_q;
    assign l1_msg_addr      = {line_q, {OFF_W{1'b0}}};
    assign wb_valid         = (state_q == ST_WB);
    assign wb_addr          = {line_q, {OFF_W{1'b0}}};
    assign arr_wr_en        = (state_q == ST_UPDATE);
    assign arr_wr_index     = line_q[IDX_W-1:0];
    assign arr_wr_way       = way_q;
    assign arr_wr_state     = new_state_q;

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed vector table, hand-written
// corner sequences and random snoops against a rule-table reference model.
module tb_snoop_responder;

    localparam int WAYS  = 8;
    localparam int TAG_W = 11;
    localparam int NV    = 14;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  snp_valid;
    logic                  snp_ready;
    logic [3:0]            snp_cmd;
    logic [31:0]           snp_addr;
    logic                  arr_rd_en;
    logic [14:0]           arr_rd_index;
    logic [WAYS*TAG_W-1:0] arr_rd_tag;
    logic [WAYS*2-1:0]     arr_rd_state;
    logic                  arr_wr_en;
    logic [14:0]           arr_wr_index;
    logic [2:0]            arr_wr_way;
    logic [1:0]            arr_wr_state;
    logic                  snp_result_valid;
    logic [1:0]            snp_result;
    logic                  l1_msg_valid;
    logic [2:0]            l1_msg;
    logic [31:0]           l1_msg_addr;
    logic                  l1_msg_ready;
    logic                  wb_valid;
    logic [31:0]           wb_addr;
    logic                  wb_ready;
    logic                  err;

    snoop_responder dut (
        .clk(clk), .rst(rst),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
        .arr_rd_en(arr_rd_en), .arr_rd_index(arr_rd_index),
        .arr_rd_tag(arr_rd_tag), .arr_rd_state(arr_rd_state),
        .arr_wr_en(arr_wr_en), .arr_wr_index(arr_wr_index),
        .arr_wr_way(arr_wr_way), .arr_wr_state(arr_wr_state),
        .snp_result_valid(snp_result_valid), .snp_result(snp_result),
        .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg), .l1_msg_addr(l1_msg_addr),
        .l1_msg_ready(l1_msg_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Contents of the set the array returns for the current snoop.
    logic [TAG_W-1:0] set_tag   [WAYS];
    logic [1:0]       set_state [WAYS];

    // Array read port: valid data only in the cycle after arr_rd_en, junk otherwise.
    initial begin : array_port
        bit rd_prev;
        rd_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int w = 0; w < WAYS; w++) begin
                arr_rd_tag[w*TAG_W +: TAG_W] = rd_prev ? set_tag[w] : TAG_W'($urandom);
                arr_rd_state[w*2 +: 2]       = rd_prev ? set_state[w] : 2'($urandom);
            end
            rd_prev = arr_rd_en;
        end
    end

    typedef struct {
        logic [1:0] res;
        logic [2:0] msg;
        bit         wb;
        bit         wr;
        int         way;
        logic [1:0] nst;
        int         err;
    } exp_t;

    typedef struct {
        int          rd_cnt, rd_cycle;
        logic [14:0] rd_idx;
        int          res_cnt, res_cycle;
        logic [1:0]  res;
        int          err_cnt, err_cycle;
        int          msg_cnt, msg_done;
        logic [2:0]  msg;
        logic [31:0] msg_addr;
        bit          msg_stable;
        int          wb_cnt, wb_first;
        logic [31:0] wb_addr;
        bit          wb_stable;
        int          wr_cnt;
        logic [2:0]  wr_way;
        logic [1:0]  wr_state;
        logic [14:0] wr_idx;
        int          idle_cycle;
    } obs_t;

    // Reference rules: command, MESI of the hit way -> result, message, wb, write, new state, err.
    typedef struct {
        logic [3:0] cmd;
        logic [1:0] mesi;
        logic [1:0] res;
        logic [2:0] msg;
        bit         wb;
        bit         wr;
        logic [1:0] nst;
        int         err;
    } rule_t;
    rule_t rules [9];

    function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] addr);
        exp_t e;
        int   first;
        int   nhit;
        first = -1;
        nhit  = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_state[w] != 2'd0 && set_tag[w] == addr[31:21]) begin
                if (first < 0) first = w;
                nhit++;
            end
        end
        e = '{res: 2'd2, msg: 3'd0, wb: 1'b0, wr: 1'b0, way: 0, nst: 2'd0, err: 0};
        e.err = (nhit > 1) ? 1 : 0;
        if (first >= 0) begin
            e.way = first;
            for (int r = 0; r < 9; r++) begin
                if (rules[r].cmd == cmd && rules[r].mesi == set_state[first]) begin
                    e.res = rules[r].res;
                    e.msg = rules[r].msg;
                    e.wb  = rules[r].wb;
                    e.wr  = rules[r].wr;
                    e.nst = rules[r].nst;
                    if (rules[r].err != 0) e.err = 1;
                end
            end
        end
        return e;
    endfunction

    // Issue one snoop and record what the DUT does, cycle numbers relative to acceptance.
    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr,
                           input int l1_stall, input int wb_stall, output obs_t o);
        int guard;
        o = '{default: 0};
        o.msg_stable = 1'b1;
        o.wb_stable  = 1'b1;
        o.idle_cycle = -1;
        guard = 0;
        while (!snp_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        snp_valid    = 1'b1;
        snp_cmd      = cmd;
        snp_addr     = addr;
        l1_msg_ready = (l1_stall == 0);
        wb_ready     = (wb_stall == 0);
        @(negedge clk);
        snp_valid = 1'b0;
        snp_cmd   = 4'($urandom);
        snp_addr  = $urandom;
        for (int c = 1; c <= 60; c++) begin
            if (arr_rd_en) begin
                o.rd_cnt++;
                o.rd_cycle = c;
                o.rd_idx   = arr_rd_index;
            end
            if (err) begin
                o.err_cnt++;
                o.err_cycle = c;
            end
            if (snp_result_valid) begin
                o.res_cnt++;
                o.res_cycle = c;
                o.res       = snp_result;
            end
            if (l1_msg_valid) begin
                if (o.msg_cnt == 0) begin
                    o.msg      = l1_msg;
                    o.msg_addr = l1_msg_addr;
                end else if (l1_msg !== o.msg || l1_msg_addr !== o.msg_addr) begin
                    o.msg_stable = 1'b0;
                end
                o.msg_cnt++;
                l1_msg_ready = (o.msg_cnt > l1_stall);
                if (l1_msg_ready) o.msg_done = c;
            end
            if (wb_valid) begin
                if (o.wb_cnt == 0) begin
                    o.wb_first = c;
                    o.wb_addr  = wb_addr;
                end else if (wb_addr !== o.wb_addr) begin
                    o.wb_stable = 1'b0;
                end
                o.wb_cnt++;
                wb_ready = (o.wb_cnt > wb_stall);
            end
            if (arr_wr_en) begin
                o.wr_cnt++;
                o.wr_way   = arr_wr_way;
                o.wr_state = arr_wr_state;
                o.wr_idx   = arr_wr_index;
            end
            if (snp_ready) begin
                o.idle_cycle = c;
                break;
            end
            @(negedge clk);
        end
        l1_msg_ready = 1'b0;
        wb_ready     = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [31:0] addr, input int l1_stall,
                          input int wb_stall, input exp_t e, input obs_t o);
        logic [31:0] line;
        int          exp_idle;
        line     = {addr[31:6], 6'b0};
        exp_idle = 4 + ((e.msg != 3'd0) ? 1 + l1_stall : 0) + (e.wb ? 1 + wb_stall : 0)
                     + (e.wr ? 1 : 0);
        check({tag, " rd_count"}, o.rd_cnt, 1);
        check({tag, " rd_cycle"}, o.rd_cycle, 1);
        check({tag, " rd_index"}, {17'b0, o.rd_idx}, {17'b0, addr[20:6]});
        check({tag, " result_count"}, o.res_cnt, 1);
        check({tag, " result_cycle"}, o.res_cycle, 3);
        check({tag, " result"}, {30'b0, o.res}, {30'b0, e.res});
        check({tag, " err_count"}, o.err_cnt, e.err);
        if (e.err != 0) check({tag, " err_cycle"}, o.err_cycle, 2);
        check({tag, " l1_cycles"}, o.msg_cnt, (e.msg != 3'd0) ? 1 + l1_stall : 0);
        if (e.msg != 3'd0) begin
            check({tag, " l1_msg"}, {29'b0, o.msg}, {29'b0, e.msg});
            check({tag, " l1_addr"}, o.msg_addr, line);
            check({tag, " l1_stable"}, {31'b0, o.msg_stable}, 1);
        end
        check({tag, " wb_cycles"}, o.wb_cnt, e.wb ? 1 + wb_stall : 0);
        if (e.wb) begin
            check({tag, " wb_addr"}, o.wb_addr, line);
            check({tag, " wb_stable"}, {31'b0, o.wb_stable}, 1);
            if (e.msg != 3'd0) check({tag, " wb_after_l1"}, {31'b0, o.wb_first > o.msg_done}, 1);
        end
        check({tag, " wr_count"}, o.wr_cnt, e.wr ? 1 : 0);
        if (e.wr) begin
            check({tag, " wr_way"}, {29'b0, o.wr_way}, e.way);
            check({tag, " wr_state"}, {30'b0, o.wr_state}, {30'b0, e.nst});
            check({tag, " wr_index"}, {17'b0, o.wr_idx}, {17'b0, addr[20:6]});
        end
        check({tag, " idle_cycle"}, o.idle_cycle, exp_idle);
    endtask

    typedef struct {
        logic [3:0]  cmd;
        int          way;
        logic [1:0]  mesi;
        logic [10:0] atag;
        int          l1s, wbs;
        logic [1:0]  res;
        logic [2:0]  msg;
        bit          wb, wr;
        logic [1:0]  nst;
        int          err;
    } vec_t;

    initial begin : main
        vec_t        vecs [NV];
        obs_t        o;
        exp_t        e;
        logic [31:0] addr;
        logic [3:0]  cmd;
        int          l1s, wbs, bad;
        logic [10:0] pool [3];

        rules[0] = '{4'd4, 2'd3, 2'd1, 3'd1, 1'b1, 1'b1, 2'd2, 0};
        rules[1] = '{4'd4, 2'd1, 2'd0, 3'd0, 1'b0, 1'b1, 2'd2, 0};
        rules[2] = '{4'd4, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 2'd2, 0};
        rules[3] = '{4'd6, 2'd3, 2'd1, 3'd4, 1'b1, 1'b1, 2'd0, 0};
        rules[4] = '{4'd6, 2'd1, 2'd0, 3'd3, 1'b0, 1'b1, 2'd0, 0};
        rules[5] = '{4'd6, 2'd2, 2'd0, 3'd3, 1'b0, 1'b1, 2'd0, 0};
        rules[6] = '{4'd3, 2'd2, 2'd0, 3'd3, 1'b0, 1'b1, 2'd0, 0};
        rules[7] = '{4'd3, 2'd3, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 1};
        rules[8] = '{4'd3, 2'd1, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 1};

        //           cmd   way mesi  atag     l1 wb  res   msg   wb    wr    nst   err
        vecs[0]  = '{4'd4,  3, 2'd3, 11'h055, 0, 0, 2'd1, 3'd1, 1'b1, 1'b1, 2'd2, 0};
        vecs[1]  = '{4'd4,  3, 2'd1, 11'h055, 0, 0, 2'd0, 3'd0, 1'b0, 1'b1, 2'd2, 0};
        vecs[2]  = '{4'd4,  3, 2'd2, 11'h055, 0, 0, 2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[3]  = '{4'd6,  3, 2'd3, 11'h055, 0, 0, 2'd1, 3'd4, 1'b1, 1'b1, 2'd0, 0};
        vecs[4]  = '{4'd6,  5, 2'd1, 11'h055, 0, 0, 2'd0, 3'd3, 1'b0, 1'b1, 2'd0, 0};
        vecs[5]  = '{4'd6,  3, 2'd2, 11'h055, 0, 0, 2'd0, 3'd3, 1'b0, 1'b1, 2'd0, 0};
        vecs[6]  = '{4'd3,  3, 2'd2, 11'h055, 0, 0, 2'd0, 3'd3, 1'b0, 1'b1, 2'd0, 0};
        vecs[7]  = '{4'd3,  3, 2'd3, 11'h055, 0, 0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 1};
        vecs[8]  = '{4'd3,  3, 2'd1, 11'h055, 0, 0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 1};
        vecs[9]  = '{4'd5,  3, 2'd3, 11'h055, 0, 0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[10] = '{4'd4,  3, 2'd3, 11'h7aa, 0, 0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[11] = '{4'd10, 3, 2'd3, 11'h055, 0, 0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[12] = '{4'd4,  3, 2'd3, 11'h055, 5, 0, 2'd1, 3'd1, 1'b1, 1'b1, 2'd2, 0};
        vecs[13] = '{4'd6,  3, 2'd3, 11'h055, 0, 3, 2'd1, 3'd4, 1'b1, 1'b1, 2'd0, 0};

        rst = 1'b1;
        snp_valid = 1'b0;
        snp_cmd = 4'd0;
        snp_addr = 32'd0;
        l1_msg_ready = 1'b0;
        wb_ready = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            set_tag[w]   = '0;
            set_state[w] = 2'd0;
        end
        repeat (3) @(negedge clk);
        check("reset snp_ready", {31'b0, snp_ready}, 1);
        check("reset snp_result", {30'b0, snp_result}, 2);
        check("reset result_valid", {31'b0, snp_result_valid}, 0);
        check("reset arr_rd_en", {31'b0, arr_rd_en}, 0);
        check("reset arr_wr_en", {31'b0, arr_wr_en}, 0);
        check("reset l1_msg_valid", {31'b0, l1_msg_valid}, 0);
        check("reset l1_msg", {29'b0, l1_msg}, 0);
        check("reset wb_valid", {31'b0, wb_valid}, 0);
        check("reset wb_addr", wb_addr, 0);
        check("reset err", {31'b0, err}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            for (int w = 0; w < WAYS; w++) begin
                set_tag[w]   = 11'h055 ^ 11'(w + 1);
                set_state[w] = 2'd2;
            end
            set_tag[vecs[i].way]   = 11'h055;
            set_state[vecs[i].way] = vecs[i].mesi;
            addr = {vecs[i].atag, 15'h0010, 6'(i + 1)};
            e = '{res: vecs[i].res, msg: vecs[i].msg, wb: vecs[i].wb, wr: vecs[i].wr,
                  way: vecs[i].way, nst: vecs[i].nst, err: vecs[i].err};
            run_txn(vecs[i].cmd, addr, vecs[i].l1s, vecs[i].wbs, o);
            verify($sformatf("vec%0d", i), addr, vecs[i].l1s, vecs[i].wbs, e, o);
        end

        // Two ways hold the same tag: the lower way (2, in E) must be used.
        for (int w = 0; w < WAYS; w++) begin
            set_tag[w]   = 11'h300 + 11'(w);
            set_state[w] = 2'd2;
        end
        set_tag[2] = 11'h055; set_state[2] = 2'd1;
        set_tag[6] = 11'h055; set_state[6] = 2'd3;
        addr = {11'h055, 15'h0010, 6'h00};
        e = '{res: 2'd0, msg: 3'd0, wb: 1'b0, wr: 1'b1, way: 2, nst: 2'd2, err: 1};
        run_txn(4'd4, addr, 0, 0, o);
        verify("multihit", addr, 0, 0, e, o);

        // Reset while the writeback is stalled aborts the snoop completely.
        for (int w = 0; w < WAYS; w++) begin
            set_tag[w]   = 11'h300 + 11'(w);
            set_state[w] = 2'd0;
        end
        set_tag[3] = 11'h055; set_state[3] = 2'd3;
        bad = 0;
        while (!snp_ready && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        snp_valid = 1'b1; snp_cmd = 4'd4; snp_addr = addr;
        l1_msg_ready = 1'b1; wb_ready = 1'b0;
        @(negedge clk);
        snp_valid = 1'b0;
        bad = 0;
        while (!wb_valid && bad < 20) begin
            @(negedge clk);
            bad++;
        end
        check("rstwb reached_wb", {31'b0, wb_valid}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstwb wb_valid", {31'b0, wb_valid}, 0);
        check("rstwb snp_ready", {31'b0, snp_ready}, 1);
        check("rstwb arr_wr_en", {31'b0, arr_wr_en}, 0);
        check("rstwb snp_result", {30'b0, snp_result}, 2);
        rst = 1'b0;
        wb_ready = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (arr_wr_en || wb_valid || l1_msg_valid || snp_result_valid || !snp_ready) bad++;
        end
        check("rstwb quiet_after", bad, 0);
        wb_ready = 1'b0;
        l1_msg_ready = 1'b0;

        // Random snoops against the rule model; a small tag pool makes hits common.
        pool[0] = 11'h101; pool[1] = 11'h2a2; pool[2] = 11'h7f3;
        for (int n = 0; n < 200; n++) begin
            for (int w = 0; w < WAYS; w++) begin
                set_tag[w]   = pool[$urandom_range(2)];
                set_state[w] = 2'($urandom);
            end
            addr = {pool[$urandom_range(2)], 15'($urandom), 6'($urandom)};
            case ($urandom_range(4))
                0:       cmd = 4'd3;
                1:       cmd = 4'd4;
                2:       cmd = 4'd5;
                3:       cmd = 4'd6;
                default: cmd = 4'($urandom);
            endcase
            l1s = $urandom_range(2);
            wbs = $urandom_range(2);
            e = model(cmd, addr);
            run_txn(cmd, addr, l1s, wbs, o);
            verify($sformatf("rnd%0d cmd%0d", n, cmd), addr, l1s, wbs, e, o);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
